// File: rtl/sat_narrow_rx.sv
// sat_narrow_rx: saturate WIDTH-bit signed words to WIDTH-SHIFT bits through a 2-entry valid/ready FIFO
//   in_valid/in_ready/in_data    : upstream handshake, WIDTH-bit signed words
//   out_valid/out_ready/out_data : downstream handshake, OW-bit signed saturated words
//   out_sat                      : out_data was clamped
//   clr_cnt/sat_cnt              : clamped-word counter, only with SAT_NARROW_RX_CNT_EN defined
module sat_narrow_rx #(
  parameter int WIDTH = 32,
  parameter int SHIFT = 3,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-SHIFT-1:0] out_data,
  output logic                   out_sat,
  input  logic                   clr_cnt,
  output logic [CNT_W-1:0]       sat_cnt
);
  localparam int OW = WIDTH - SHIFT;
  localparam logic [WIDTH-1:0] MAX = {{(SHIFT+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN = {{(SHIFT+1){1'b1}}, {(OW-1){1'b0}}};
  logic [1:0]  count_q, count_d;
  logic        wr_q, wr_d, rd_q, rd_d;
  logic [OW:0] mem_q [2];
  logic [OW:0] mem_d [2];
  logic [OW:0] wdat;
  logic        push, pop;
  assign in_ready  = count_q != 2'd2;
  assign out_valid = count_q != 2'd0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem_q[rd_q][OW-1:0];
  assign out_sat   = mem_q[rd_q][OW];
  always_comb begin
    wdat     = ($signed(in_data) > $signed(MAX)) ? {1'b1, MAX[OW-1:0]} :
               ($signed(in_data) < $signed(MIN)) ? {1'b1, MIN[OW-1:0]} : {1'b0, in_data[OW-1:0]};
    mem_d[0] = (push && !wr_q) ? wdat : mem_q[0];
    mem_d[1] = (push && wr_q) ? wdat : mem_q[1];
    wr_d     = push ? !wr_q : wr_q;
    rd_d     = pop ? !rd_q : rd_q;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      count_q  <= count_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
    end
  end
`ifdef SAT_NARROW_RX_CNT_EN
  logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;
  // holds at all-ones; clear beats a same-cycle increment
  always_comb
    sat_cnt_d = clr_cnt ? '0 :
                (pop && out_sat && !(&sat_cnt_q)) ? sat_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : sat_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sat_cnt_q <= '0;
    else sat_cnt_q <= sat_cnt_d;
  end
  assign sat_cnt = sat_cnt_q;
`else
  logic unused_clr;
  assign unused_clr = clr_cnt;
  assign sat_cnt    = '0;
`endif
endmodule
